// File: rtl/lif_spike_aer_encoder.sv
// lif_spike_aer_encoder
// Collects per-neuron spike lines into a pending vector, priority-encodes the
// lowest pending neuron into an address-event word each cycle and queues it in
// a small circular FIFO drained over a valid/ready handshake. Spikes that land
// on a neuron already pending (and not being encoded this edge) are counted in
// a saturating drop counter.
// Optional feature: define LIF_AER_TIMESTAMP_EN to add a free-running
// timestamp counter whose value at the push edge is stored with each event.
module lif_spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int ADDR_W     = 3,
`ifdef LIF_AER_TIMESTAMP_EN
    parameter int TS_W       = 8,
`endif
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ADDR_W-1:0]    ev_addr,
`ifdef LIF_AER_TIMESTAMP_EN
    output logic [TS_W-1:0]      ev_ts,
`endif
    output logic                 fifo_full,
    output logic [7:0]           drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int POP_W = $clog2(N_NEURONS + 1);
`ifdef LIF_AER_TIMESTAMP_EN
    localparam int ENTRY_W = ADDR_W + TS_W;
`else
    localparam int ENTRY_W = ADDR_W;
`endif

    // Number of set bits in a spike vector.
    function automatic logic [POP_W-1:0] count_ones(input logic [N_NEURONS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Add to an 8-bit counter, clamping at 255 instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [POP_W-1:0] b);
        logic [15:0] sum;
        sum = 16'(a) + 16'(b);
        return (sum > 16'd255) ? 8'hFF : sum[7:0];
    endfunction

    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   entry_d;
    logic [ADDR_W-1:0]    enc_addr;
    logic [N_NEURONS-1:0] clr_mask;
    logic [N_NEURONS-1:0] drop_bits;
    logic                 push;
    logic                 pop;
    logic                 full;
`ifdef LIF_AER_TIMESTAMP_EN
    logic [TS_W-1:0]      ts_q, ts_d;
`endif

    // Encoder, pending update, drop accounting and FIFO pointer/occupancy next state.
    always_comb begin
        full      = (occ_q == OCC_W'(FIFO_DEPTH));
        pop       = (occ_q != '0) && ev_ready;
        // Scan downwards so the lowest-index pending neuron is the one selected.
        enc_addr  = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enc_addr = ADDR_W'(i);
            end
        end
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        push      = ena && (pending_q != '0) && (!full || pop);
        clr_mask  = push ? (N_NEURONS'(1) << enc_addr) : '0;
        // A fresh spike on the neuron being cleared re-arms it and is not a drop.
        pending_d = ena ? ((pending_q & ~clr_mask) | spike_in) : pending_q;
        drop_bits = ena ? (spike_in & pending_q & ~clr_mask) : '0;
        drop_cnt_d = sat_add8(drop_cnt_q, count_ones(drop_bits));
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        occ_d     = occ_q + OCC_W'(push) - OCC_W'(pop);
`ifdef LIF_AER_TIMESTAMP_EN
        ts_d      = ena ? ts_q + TS_W'(1) : ts_q;
        entry_d   = {ts_q, enc_addr};
`else
        entry_d   = enc_addr;
`endif
    end

    // Control state: pending spikes, FIFO pointers, occupancy, drop counter, timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            drop_cnt_q <= '0;
`ifdef LIF_AER_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            pending_q  <= pending_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef LIF_AER_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // Event storage; contents are only observed through a valid head slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    // Head-of-queue outputs; the head is masked to zero while the FIFO is empty.
    always_comb begin
        ev_valid  = (occ_q != '0);
        fifo_full = full;
        drop_cnt  = drop_cnt_q;
        ev_addr   = ev_valid ? mem_q[rd_ptr_q][ADDR_W-1:0] : '0;
`ifdef LIF_AER_TIMESTAMP_EN
        ev_ts     = ev_valid ? mem_q[rd_ptr_q][ENTRY_W-1:ADDR_W] : '0;
`endif
    end

endmodule

// File: tb/tb_lif_spike_aer_encoder.sv
// Directed bench for lif_spike_aer_encoder (default parameters).
// Build with LIF_AER_TIMESTAMP_EN defined to also exercise the timestamp path.
module tb_lif_spike_aer_encoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] spike_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_addr;
    logic       fifo_full;
    logic [7:0] drop_cnt;
`ifdef LIF_AER_TIMESTAMP_EN
    logic [7:0] ev_ts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    lif_spike_aer_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spike_in  (spike_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_addr   (ev_addr),
`ifdef LIF_AER_TIMESTAMP_EN
        .ev_ts     (ev_ts),
`endif
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ena      = 1'b1;
        spike_in = 8'h00;
        ev_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b0;
        spike_in = 8'h00;
        ev_ready = 1'b0;
        #2;
        chk("rst_valid", ev_valid, 0);
        chk("rst_addr", ev_addr, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_drop", drop_cnt, 0);
        do_reset();

        // Mid-stream reset with three events queued and two drops recorded.
        tick();
        spike_in = 8'h07; tick();         // capture 0,1,2
        spike_in = 8'h06; tick();         // push 0; bits 1,2 re-spiked -> 2 drops
        spike_in = 8'h00; tick(); tick(); // push 1, push 2
        chk("t1_queued_valid", ev_valid, 1);
        chk("t1_queued_head", ev_addr, 0);
        chk("t1_drops", drop_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid", ev_valid, 0);
        chk("t1_async_drop", drop_cnt, 0);
        chk("t1_async_full", fifo_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        spike_in = 8'h08;
        tick();                           // capture
        spike_in = 8'h00;
        chk("t1_lat_e0", ev_valid, 0);
        tick();                           // push
        chk("t1_lat_e1_valid", ev_valid, 1);
        chk("t1_lat_e1_addr", ev_addr, 3);

        // Three spikes in one cycle drain in ascending address order.
        do_reset();
        ev_ready = 1'b1;
        spike_in = 8'b1010_0100;
        tick();
        spike_in = 8'h00;
        chk("t2_e0_valid", ev_valid, 0);
        tick();
        chk("t2_ev0_valid", ev_valid, 1);
        chk("t2_ev0_addr", ev_addr, 2);
        tick();
        chk("t2_ev1_addr", ev_addr, 5);
        tick();
        chk("t2_ev2_addr", ev_addr, 7);
        tick();
        chk("t2_empty", ev_valid, 0);
        chk("t2_drop", drop_cnt, 0);

        // Fill the FIFO, hold, then drain all eight back-to-back.
        do_reset();
        spike_in = 8'hFF;
        tick();
        spike_in = 8'h00;
        repeat (4) tick();
        chk("t3_full", fifo_full, 1);
        chk("t3_head", ev_addr, 0);
        tick();
        chk("t3_hold_addr", ev_addr, 0);
        chk("t3_hold_valid", ev_valid, 1);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_valid", ev_valid, 1);
            chk("t3_drain_addr", ev_addr, i);
            if (i == 1) chk("t3_full_push_pop", fifo_full, 1);
            tick();
        end
        chk("t3_drained", ev_valid, 0);
        chk("t3_drop", drop_cnt, 0);

        // Level-high neuron 0 against a stalled consumer.
        do_reset();
        spike_in = 8'h01;
        repeat (10) tick();               // 4 pushes fill the FIFO, then 5 drops
        chk("t4_drop10", drop_cnt, 5);
        chk("t4_full", fifo_full, 1);
        repeat (290) tick();
        chk("t4_drop_sat", drop_cnt, 255);
        spike_in = 8'h00;

        // Disabled capture; queued events still drain.
        do_reset();
        spike_in = 8'h30;
        tick();
        spike_in = 8'h00;
        tick(); tick();                   // push 4, push 5
        ena = 1'b0;
        spike_in = 8'h01;
        chk("t5_head", ev_addr, 4);
        ev_ready = 1'b1;
        tick();
        chk("t5_drain_addr", ev_addr, 5);
        tick();
        chk("t5_drained", ev_valid, 0);
        tick(); tick();
        chk("t5_no_event", ev_valid, 0);
        spike_in = 8'h00;
        ena = 1'b1;
        tick(); tick();
        chk("t5_not_captured", ev_valid, 0);
        chk("t5_drop", drop_cnt, 0);

`ifdef LIF_AER_TIMESTAMP_EN
        // Timestamp stored at the push edge, including counter wrap.
        do_reset();
        repeat (254) tick();              // counter = 254
        spike_in = 8'h01;
        tick();                           // capture, counter -> 255
        spike_in = 8'h00;
        tick();                           // push with 255, counter -> 0
        chk("t6_ts255_valid", ev_valid, 1);
        chk("t6_ts255", ev_ts, 255);
        ev_ready = 1'b1;
        tick();                           // pop, counter -> 1
        ev_ready = 1'b0;
        spike_in = 8'h02;
        tick();                           // capture, counter -> 2
        spike_in = 8'h00;
        tick();                           // push with 2
        chk("t6_ts2_addr", ev_addr, 1);
        chk("t6_ts2", ev_ts, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
